// File: rtl/tiros_pkg.sv
// tiros_pkg -- definitions shared by the ship shot logic.
//   estado_t      : fire FSM states (PRONTO, RECARGA, ESPERA_SOLTAR)
//   ALTURA_TIRO   : shot sprite height, in pixels
//   LARGURA_TIRO  : shot sprite width, in pixels
//   LARGURA_TELA / ALTURA_TELA : visible screen limits
package tiros_pkg;

   typedef enum logic [1:0] {
      PRONTO        = 2'd0,
      RECARGA       = 2'd1,
      ESPERA_SOLTAR = 2'd2
   } estado_t;

   localparam int ALTURA_TIRO  = 8;
   localparam int LARGURA_TIRO = 2;
   localparam int LARGURA_TELA = 640;
   localparam int ALTURA_TELA  = 480;

endpackage

// File: rtl/divisor_tick.sv
// divisor_tick -- movement tick generator.
//   CLOCK_50   in  : system clock
//   resetBarra in  : asynchronous, active-high reset
//   tick       out : high for one cycle every TICK_DIV cycles
// The counter runs 0..TICK_DIV-1 and the tick is the terminal count, so the
// first tick after reset appears TICK_DIV-1 cycles after reset is released.
module divisor_tick #(
   parameter int TICK_DIV = 833333
) (
   input  logic CLOCK_50,
   input  logic resetBarra,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge CLOCK_50 or posedge resetBarra) begin
      if (resetBarra)  cnt <= '0;
      else if (tick)   cnt <= '0;
      else             cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/tiros_nave.sv
// tiros_nave -- ship shot slots: fire FSM with cooldown, spawn, upward
// movement on ticks and removal on hit or when leaving the top of the screen.
//   CLOCK_50, resetBarra (async, active-high)
//   disparo                    : fire request level (synchronous)
//   xNave, yNave, larguraNave  : ship position / width
//   acerto, acertoIdx          : hit pulse and the slot it hit
//   tiroAtivo                  : per-slot active flags
//   tiroX, tiroY               : packed slot coordinates, slot i at [10i+9:10i]
//   disparoOk                  : one-cycle pulse when a shot was spawned
// Build option: TIROS_AUTOFIRE_EN -- a held disparo refires every
// RECARGA_TICKS ticks instead of requiring a release between shots.
module tiros_nave
   import tiros_pkg::*;
#(
   parameter int NUM_TIROS     = 4,
   parameter int PASSO         = 4,
   parameter int TICK_DIV      = 833333,
   parameter int RECARGA_TICKS = 10
) (
   input  logic                    CLOCK_50,
   input  logic                    resetBarra,
   input  logic                    disparo,
   input  logic [9:0]              xNave,
   input  logic [9:0]              yNave,
   input  logic [9:0]              larguraNave,
   input  logic                    acerto,
   input  logic [1:0]              acertoIdx,
   output logic [NUM_TIROS-1:0]    tiroAtivo,
   output logic [10*NUM_TIROS-1:0] tiroX,
   output logic [10*NUM_TIROS-1:0] tiroY,
   output logic                    disparoOk
);

   localparam int CW = (RECARGA_TICKS > 0) ? $clog2(RECARGA_TICKS + 1) : 1;

   logic           tick;
   estado_t        estado, prox;
   logic [CW-1:0]  recarga;
   logic [NUM_TIROS-1:0] sel;
   logic           livre;
   logic           aceita;
   logic [9:0]     x_novo, y_novo;

   divisor_tick #(.TICK_DIV(TICK_DIV)) u_div (
      .CLOCK_50   (CLOCK_50),
      .resetBarra (resetBarra),
      .tick       (tick)
   );

   // Lowest free slot from the registered flags: a slot freed this cycle
   // still reads active here, so it only becomes spawnable next cycle.
   always_comb begin
      sel   = '0;
      livre = 1'b0;
      for (int i = 0; i < NUM_TIROS; i++) begin
         if (!tiroAtivo[i] && !livre) begin
            sel[i] = 1'b1;
            livre  = 1'b1;
         end
      end
   end

   assign aceita = (estado == PRONTO) && disparo && livre;
   assign x_novo = xNave + (larguraNave >> 1) - 10'd1;
   assign y_novo = yNave - 10'(ALTURA_TIRO);

   always_ff @(posedge CLOCK_50 or posedge resetBarra) begin
      if (resetBarra) estado <= PRONTO;
      else            estado <= prox;
   end

   always_comb begin
      prox = estado;
      case (estado)
         PRONTO:  if (aceita) prox = RECARGA;
         RECARGA: begin
            if (recarga == '0) begin
`ifdef TIROS_AUTOFIRE_EN
               prox = PRONTO;
`else
               prox = disparo ? ESPERA_SOLTAR : PRONTO;
`endif
            end
         end
         ESPERA_SOLTAR: if (!disparo) prox = PRONTO;
         default: prox = PRONTO;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge resetBarra) begin
      if (resetBarra) begin
         recarga   <= '0;
         disparoOk <= 1'b0;
      end else begin
         disparoOk <= aceita;
         if (aceita)                     recarga <= CW'(RECARGA_TICKS);
         else if (tick && recarga != '0) recarga <= recarga - 1'b1;
      end
   end

   // Per-slot state. Spawn only targets an inactive slot, so it never
   // meets a hit or a move; for an active slot a hit beats movement.
   for (genvar g = 0; g < NUM_TIROS; g++) begin : g_slot
      logic       ativo;
      logic [9:0] x, y;

      always_ff @(posedge CLOCK_50 or posedge resetBarra) begin
         if (resetBarra) begin
            ativo <= 1'b0;
            x     <= '0;
            y     <= '0;
         end else if (aceita && sel[g]) begin
            ativo <= 1'b1;
            x     <= x_novo;
            y     <= y_novo;
         end else if (ativo) begin
            if (acerto && (int'(acertoIdx) == g)) begin
               ativo <= 1'b0;
            end else if (tick) begin
               if (y < 10'(PASSO)) ativo <= 1'b0;
               else                y     <= y - 10'(PASSO);
            end
         end
      end

      assign tiroAtivo[g]       = ativo;
      assign tiroX[10*g +: 10]  = x;
      assign tiroY[10*g +: 10]  = y;
   end

endmodule

// File: tb/tb_tiros_nave.sv
// tb_tiros_nave -- directed bench for tiros_nave with TICK_DIV=4,
// RECARGA_TICKS=2, PASSO=4. Inputs change 1 ns after the rising edge and
// outputs are read there too. n_borda counts edges since reset release; the
// tick is consumed on edges where n_borda is a multiple of 4.
// With TIROS_AUTOFIRE_EN defined the held-fire scenario checks autofire.
module tb_tiros_nave;

   logic        CLOCK_50 = 1'b0;
   logic        resetBarra = 1'b1;
   logic        disparo = 1'b0;
   logic [9:0]  xNave = 10'd270;
   logic [9:0]  yNave = 10'd424;
   logic [9:0]  larguraNave = 10'd20;
   logic        acerto = 1'b0;
   logic [1:0]  acertoIdx = 2'd0;
   logic [3:0]  tiroAtivo;
   logic [39:0] tiroX, tiroY;
   logic        disparoOk;

   int n_cmp = 0;
   int n_err = 0;
   int n_borda = 0;
   int pulsos = 0;
   int borda_pulso [64];
   int p0;

   tiros_nave #(
      .NUM_TIROS(4), .PASSO(4), .TICK_DIV(4), .RECARGA_TICKS(2)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .resetBarra  (resetBarra),
      .disparo     (disparo),
      .xNave       (xNave),
      .yNave       (yNave),
      .larguraNave (larguraNave),
      .acerto      (acerto),
      .acertoIdx   (acertoIdx),
      .tiroAtivo   (tiroAtivo),
      .tiroX       (tiroX),
      .tiroY       (tiroY),
      .disparoOk   (disparoOk)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      if (resetBarra) n_borda <= 0;
      else            n_borda <= n_borda + 1;
   end

   // Records every disparoOk pulse and the edge that produced it.
   always @(negedge CLOCK_50) begin
      if (disparoOk) begin
         if (pulsos < 64) borda_pulso[pulsos] <= n_borda;
         pulsos <= pulsos + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic ciclo();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic reinicia();
      resetBarra = 1'b1;
      disparo    = 1'b0;
      acerto     = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      #1;
      resetBarra = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end within time limit");
      $fatal(1);
   end

   initial begin
      // ---- reset state, single shot ----
      reinicia();
      chk("rst_ativo", tiroAtivo, 4'h0);
      chk("rst_x", tiroX, 40'd0);
      chk("rst_y", tiroY, 40'd0);
      chk("rst_ok", disparoOk, 1'b0);
      disparo = 1'b1;
      ciclo();                               // E1: spawn + disparoOk
      disparo = 1'b0;
      chk("s1_ativo", tiroAtivo, 4'h1);
      chk("s1_x0", tiroX[9:0], 10'd279);
      chk("s1_y0", tiroY[9:0], 10'd416);
      chk("s1_ok", disparoOk, 1'b1);
      ciclo();                               // E2
      chk("s1_ok_fim", disparoOk, 1'b0);
      chk("s1_y0_fixo", tiroY[9:0], 10'd416);

`ifdef TIROS_AUTOFIRE_EN
      // ---- held fire: spawns on edges 1,10,18,26, fifth request dropped ----
      reinicia();
      p0 = pulsos;
      disparo = 1'b1;
      repeat (40) ciclo();
      disparo = 1'b0;
      chk("af_ativo", tiroAtivo, 4'hF);
      chk("af_pulsos", pulsos - p0, 4);
      chk("af_b0", borda_pulso[p0],     1);
      chk("af_b1", borda_pulso[p0 + 1], 10);
      chk("af_b2", borda_pulso[p0 + 2], 18);
      chk("af_b3", borda_pulso[p0 + 3], 26);
      chk("af_y0", tiroY[9:0], 10'd376);
`else
      // ---- held fire: one shot; release, press -> slot 1 ----
      reinicia();
      p0 = pulsos;
      disparo = 1'b1;
      repeat (16) ciclo();                   // ticks on E4,8,12,16
      chk("hd_ativo", tiroAtivo, 4'h1);
      chk("hd_pulsos", pulsos - p0, 1);
      chk("hd_y0", tiroY[9:0], 10'd400);
      disparo = 1'b0;
      ciclo();                               // E17: back to PRONTO
      disparo = 1'b1;
      ciclo();                               // E18: second spawn
      disparo = 1'b0;
      chk("hd2_ativo", tiroAtivo, 4'h3);
      chk("hd2_x1", tiroX[19:10], 10'd279);
      chk("hd2_y1", tiroY[19:10], 10'd416);
      chk("hd2_ok", disparoOk, 1'b1);
      chk("hd2_y0", tiroY[9:0], 10'd400);
`endif

      // ---- top boundary: y=6 -> 2 -> cleared ----
      reinicia();
      yNave = 10'd14;
      disparo = 1'b1;
      ciclo();                               // E1
      disparo = 1'b0;
      chk("top_y_ini", tiroY[9:0], 10'd6);
      repeat (3) ciclo();                    // E4 tick
      chk("top_y_t1", tiroY[9:0], 10'd2);
      chk("top_ativo_t1", tiroAtivo, 4'h1);
      repeat (3) ciclo();                    // E7
      chk("top_ativo_e7", tiroAtivo, 4'h1);
      ciclo();                               // E8 tick: 2 < 4 clears
      chk("top_ativo_t2", tiroAtivo, 4'h0);
      chk("top_y_held", tiroY[9:0], 10'd2);
      chk("top_x_held", tiroX[9:0], 10'd279);
      yNave = 10'd424;

      // ---- hit on slot 1 with tick and simultaneous request ----
      reinicia();
      disparo = 1'b1;
      ciclo();                               // E1 slot0
      disparo = 1'b0;
      repeat (8) ciclo();                    // E9 PRONTO
      disparo = 1'b1;
      ciclo();                               // E10 slot1
      disparo = 1'b0;
      chk("hit_pre_ativo", tiroAtivo, 4'h3);
      repeat (9) ciclo();                    // E19: tick window, PRONTO
      acerto = 1'b1;
      acertoIdx = 2'd1;
      disparo = 1'b1;
      ciclo();                               // E20
      acerto = 1'b0;
      disparo = 1'b0;
      chk("hit_ativo", tiroAtivo, 4'h5);
      chk("hit_y1_fixo", tiroY[19:10], 10'd408);
      chk("hit_x2", tiroX[29:20], 10'd279);
      chk("hit_y2", tiroY[29:20], 10'd416);
      chk("hit_y0", tiroY[9:0], 10'd396);
      chk("hit_ok", disparoOk, 1'b1);
      acerto = 1'b1;
      acertoIdx = 2'd3;                      // inactive slot: ignored
      ciclo();                               // E21
      acerto = 1'b0;
      chk("hit_inativo", tiroAtivo, 4'h5);

      // ---- reset mid-flight with three shots ----
      repeat (8) ciclo();                    // E29 PRONTO
      disparo = 1'b1;
      ciclo();                               // E30 slot1 again
      disparo = 1'b0;
      chk("mr_pre_ativo", tiroAtivo, 4'h7);
      #2;
      resetBarra = 1'b1;
      #1;
      chk("mr_ativo", tiroAtivo, 4'h0);
      chk("mr_x", tiroX, 40'd0);
      chk("mr_y", tiroY, 40'd0);
      chk("mr_ok", disparoOk, 1'b0);
      disparo = 1'b1;
      repeat (2) @(posedge CLOCK_50);
      #1;
      chk("mr_sem_spawn", tiroAtivo, 4'h0);
      resetBarra = 1'b0;
      ciclo();                               // E1 after release
      disparo = 1'b0;
      chk("mr_novo_ativo", tiroAtivo, 4'h1);
      chk("mr_novo_ok", disparoOk, 1'b1);
      chk("mr_novo_y0", tiroY[9:0], 10'd416);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
